// File: rtl/ysyx_25020037_axi_arbiter.sv
// Shares the core's single AXI4 master port between the IFU (read-only) and the LSU (read/write).
// One transaction at a time: writes first, simultaneous reads alternate, registered grant drives a pure mux.
module ysyx_25020037_axi_arbiter (
    input  logic        clk,
    input  logic        rst,
    // IFU read
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    input  logic [3:0]  ifu_arid,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    output logic [3:0]  ifu_rid,
    // LSU read
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [3:0]  lsu_arid,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    input  logic [1:0]  lsu_arburst,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rlast,
    output logic [3:0]  lsu_rid,
    // LSU write
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_awaddr,
    input  logic [3:0]  lsu_awid,
    input  logic [7:0]  lsu_awlen,
    input  logic [2:0]  lsu_awsize,
    input  logic [1:0]  lsu_awburst,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wlast,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [1:0]  lsu_bresp,
    output logic [3:0]  lsu_bid,
    // downstream master
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_awaddr,
    output logic [3:0]  m_awid,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    input  logic        m_bvalid,
    output logic        m_bready,
    input  logic [1:0]  m_bresp,
    input  logic [3:0]  m_bid,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic [3:0]  m_rid
);

    typedef enum logic [1:0] {IDLE, IFU_R, LSU_R, LSU_W} state_t;

    state_t state, state_nxt;
    logic   last_rd, last_rd_nxt;   // 0: IFU served last, 1: LSU served last
    logic   sel_ifu, sel_lsu, sel_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_rd <= 1'b1;
        end else begin
            state   <= state_nxt;
            last_rd <= last_rd_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_rd_nxt = last_rd;
        unique case (state)
            IDLE: begin
                if (lsu_awvalid)                     state_nxt = LSU_W;
                else if (ifu_arvalid && lsu_arvalid) state_nxt = last_rd ? IFU_R : LSU_R;
                else if (ifu_arvalid)                state_nxt = IFU_R;
                else if (lsu_arvalid)                state_nxt = LSU_R;
            end
            IFU_R: if (m_rvalid && ifu_rready && m_rlast) begin
                state_nxt   = IDLE;
                last_rd_nxt = 1'b0;
            end
            LSU_R: if (m_rvalid && lsu_rready && m_rlast) begin
                state_nxt   = IDLE;
                last_rd_nxt = 1'b1;
            end
            LSU_W: if (m_bvalid && lsu_bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_ifu = (state == IFU_R);
    assign sel_lsu = (state == LSU_R);
    assign sel_w   = (state == LSU_W);

    // Read address mux; payload forced to zero when no read is granted
    always_comb begin
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_arid    = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        if (sel_ifu) begin
            m_arvalid = ifu_arvalid;
            m_araddr  = ifu_araddr;
            m_arid    = ifu_arid;
            m_arlen   = ifu_arlen;
            m_arsize  = ifu_arsize;
            m_arburst = ifu_arburst;
        end else if (sel_lsu) begin
            m_arvalid = lsu_arvalid;
            m_araddr  = lsu_araddr;
            m_arid    = lsu_arid;
            m_arlen   = lsu_arlen;
            m_arsize  = lsu_arsize;
            m_arburst = lsu_arburst;
        end
    end

    assign ifu_arready = sel_ifu & m_arready;
    assign lsu_arready = sel_lsu & m_arready;
    assign m_rready    = (sel_ifu & ifu_rready) | (sel_lsu & lsu_rready);
    assign ifu_rvalid  = sel_ifu & m_rvalid;
    assign lsu_rvalid  = sel_lsu & m_rvalid;

    // Response payloads go to both readers; only the valid is steered
    assign ifu_rdata = m_rdata;
    assign ifu_rresp = m_rresp;
    assign ifu_rlast = m_rlast;
    assign ifu_rid   = m_rid;
    assign lsu_rdata = m_rdata;
    assign lsu_rresp = m_rresp;
    assign lsu_rlast = m_rlast;
    assign lsu_rid   = m_rid;

    assign m_awvalid = sel_w & lsu_awvalid;
    assign m_awaddr  = sel_w ? lsu_awaddr  : '0;
    assign m_awid    = sel_w ? lsu_awid    : '0;
    assign m_awlen   = sel_w ? lsu_awlen   : '0;
    assign m_awsize  = sel_w ? lsu_awsize  : '0;
    assign m_awburst = sel_w ? lsu_awburst : '0;
    assign m_wvalid  = sel_w & lsu_wvalid;
    assign m_wdata   = sel_w ? lsu_wdata   : '0;
    assign m_wstrb   = sel_w ? lsu_wstrb   : '0;
    assign m_wlast   = sel_w & lsu_wlast;
    assign m_bready  = sel_w & lsu_bready;

    assign lsu_awready = sel_w & m_awready;
    assign lsu_wready  = sel_w & m_wready;
    assign lsu_bvalid  = sel_w & m_bvalid;
    assign lsu_bresp   = m_bresp;
    assign lsu_bid     = m_bid;

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter; the bench plays both masters and the downstream slave.
module tb_ysyx_25020037_axi_arbiter;

    logic        clk = 1'b0, rst;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [3:0]  lsu_arid, lsu_rid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast, lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_awid, lsu_wstrb, lsu_bid;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst, lsu_bresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_awid, m_wstrb, m_bid;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst, m_bresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [31:0] m_araddr, m_rdata;
    logic [3:0]  m_arid, m_rid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst, m_rresp;

    int n_chk = 0, n_err = 0;

    ysyx_25020037_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr), .lsu_awid(lsu_awid),
        .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wlast(lsu_wlast), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
        .lsu_bid(lsu_bid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_idle(input string tag);
        chk(tag, {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, ifu_arready, lsu_arready,
                  lsu_awready, lsu_wready, ifu_rvalid, lsu_rvalid, lsu_bvalid}, 64'd0);
    endtask

    // Raise a read request from one master; arid encodes the requester (IFU=1, LSU=2)
    task automatic req(input bit lsu, input logic [31:0] addr, input logic [7:0] len);
        if (lsu) begin
            lsu_arvalid = 1; lsu_araddr = addr; lsu_arid = 4'd2; lsu_arlen = len; lsu_arsize = 3'd2; lsu_arburst = 2'd1;
        end else begin
            ifu_arvalid = 1; ifu_araddr = addr; ifu_arid = 4'd1; ifu_arlen = len; ifu_arsize = 3'd2; ifu_arburst = 2'd1;
        end
    endtask

    // Entered in the first granted cycle; leaves in the IDLE bubble after rlast
    task automatic do_read(input bit lsu, input logic [31:0] addr, input logic [31:0] data,
                           input int beats, input bit gaps);
        chk("m_arvalid", m_arvalid, 1);
        chk("m_araddr", m_araddr, addr);
        chk("m_arid", m_arid, lsu ? 4'd2 : 4'd1);
        chk("m_arlen", m_arlen, beats - 1);
        chk("m_arburst", m_arburst, 2'd1);
        m_arready = 1;
        #1;
        chk("arready", lsu ? lsu_arready : ifu_arready, 1);
        chk("other_arready", lsu ? ifu_arready : lsu_arready, 0);
        tick;
        if (lsu) lsu_arvalid = 0; else ifu_arvalid = 0;
        for (int i = 0; i < beats; i++) begin
            if (gaps && i > 0) begin
                m_rvalid = 0;
                #1;
                chk("gap_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
                chk("gap_other_arready", lsu ? ifu_arready : lsu_arready, 0);
                tick;
            end
            m_rvalid = 1; m_rdata = data + i; m_rid = lsu ? 4'd2 : 4'd1; m_rlast = (i == beats - 1);
            #1;
            chk("rvalid", lsu ? lsu_rvalid : ifu_rvalid, 1);
            chk("other_rvalid", lsu ? ifu_rvalid : lsu_rvalid, 0);
            chk("rdata", lsu ? lsu_rdata : ifu_rdata, data + i);
            chk("rid", lsu ? lsu_rid : ifu_rid, lsu ? 4'd2 : 4'd1);
            chk("m_rready", m_rready, 1);
            chk("beat_other_arready", lsu ? ifu_arready : lsu_arready, 0);
            tick;
        end
        // m_rvalid still high here: a missed exit would forward it again
        #1;
        chk("post_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
        m_rvalid = 0; m_rlast = 0; m_arready = 0;
        #1;
        chk("bubble_rready", m_rready, 0);
        chk("bubble_arvalid", m_arvalid, 0);
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [31:0] data);
        lsu_awvalid = 1; lsu_awaddr = addr; lsu_awid = 4'd3; lsu_awlen = 0; lsu_awsize = 3'd2; lsu_awburst = 2'd1;
        lsu_wvalid = 1; lsu_wdata = data; lsu_wstrb = 4'hF; lsu_wlast = 1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        chk("m_awvalid", m_awvalid, 1);
        chk("m_awaddr", m_awaddr, addr);
        chk("m_awid", m_awid, 4'd3);
        chk("m_wvalid", m_wvalid, 1);
        chk("m_wdata", m_wdata, data);
        chk("m_wstrb", m_wstrb, 4'hF);
        chk("m_wlast", m_wlast, 1);
        chk("w_m_arvalid", m_arvalid, 0);
        m_awready = 1; m_wready = 1; m_arready = 1;
        #1;
        chk("lsu_awready", lsu_awready, 1);
        chk("lsu_wready", lsu_wready, 1);
        chk("w_ifu_arready", ifu_arready, 0);
        tick;
        lsu_awvalid = 0; lsu_wvalid = 0; m_awready = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = resp; m_bid = 4'd3;
        #1;
        chk("lsu_bvalid", lsu_bvalid, 1);
        chk("lsu_bresp", lsu_bresp, resp);
        chk("lsu_bid", lsu_bid, 4'd3);
        chk("m_bready", m_bready, 1);
        tick;
        #1;
        chk("post_bvalid", lsu_bvalid, 0);
        m_bvalid = 0; m_bresp = 0; m_arready = 0;
        #1;
        chk("w_bubble_bready", m_bready, 0);
        chk("w_bubble_awvalid", m_awvalid, 0);
    endtask

    initial begin
        rst = 1;
        {ifu_arvalid, ifu_araddr, ifu_arid, ifu_arlen, ifu_arsize, ifu_arburst} = '0;
        {lsu_arvalid, lsu_araddr, lsu_arid, lsu_arlen, lsu_arsize, lsu_arburst} = '0;
        {lsu_awvalid, lsu_awaddr, lsu_awid, lsu_awlen, lsu_awsize, lsu_awburst} = '0;
        {lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_wlast} = '0;
        {m_awready, m_wready, m_bvalid, m_bresp, m_bid, m_arready} = '0;
        {m_rvalid, m_rdata, m_rresp, m_rlast, m_rid} = '0;
        ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
        tick; tick;
        rst = 0;
        #1;
        chk_all_idle("reset_outputs");
        chk("reset_araddr", m_araddr, 0);
        chk("reset_awaddr", m_awaddr, 0);

        // First tie after reset: IFU wins, then LSU
        req(0, 32'h8000_0000, 0);
        req(1, 32'h8000_1000, 0);
        #1;
        chk("tie_latency", m_arvalid, 0);
        tick;
        do_read(0, 32'h8000_0000, 32'h1111_0000, 1, 0);
        tick;
        do_read(1, 32'h8000_1000, 32'h2222_0000, 1, 0);

        // Single IFU read
        tick;
        req(0, 32'h3000_0000, 0);
        #1;
        chk("single_latency", m_arvalid, 0);
        tick;
        do_read(0, 32'h3000_0000, 32'hDEAD_BEEF, 1, 0);

        // IFU served last, so the next tie goes to LSU
        req(0, 32'h8000_0040, 0);
        req(1, 32'h8000_1040, 0);
        tick;
        do_read(1, 32'h8000_1040, 32'h3333_0000, 1, 0);
        tick;
        do_read(0, 32'h8000_0040, 32'h4444_0000, 1, 0);

        // Write beats a pending IFU read
        start_write(32'hA000_0004, 32'h1234_5678);
        req(0, 32'h3000_0004, 0);
        tick;
        do_write(32'hA000_0004, 32'h1234_5678, 2'b00);
        tick;
        do_read(0, 32'h3000_0004, 32'h5555_0000, 1, 0);

        // IFU burst of 4 with gaps; LSU request raised mid-burst waits for rlast
        req(0, 32'h3000_0100, 8'd3);
        tick;
        req(1, 32'h8000_2000, 0);
        do_read(0, 32'h3000_0100, 32'h6666_0000, 4, 1);
        tick;
        do_read(1, 32'h8000_2000, 32'h7777_0000, 1, 0);

        // Reset while LSU read awaits data
        req(1, 32'h8000_3000, 0);
        tick;
        chk("pre_rst_arvalid", m_arvalid, 1);
        m_arready = 1;
        tick;
        lsu_arvalid = 0; m_arready = 0;
        #1;
        chk("pre_rst_rready", m_rready, 1);
        rst = 1;
        tick;
        rst = 0;
        #1;
        chk_all_idle("midtxn_reset");
        req(1, 32'h8000_3000, 0);
        tick;
        do_read(1, 32'h8000_3000, 32'h8888_0000, 1, 0);

        // SLVERR is passed through unchanged
        start_write(32'hA000_0008, 32'hCAFE_F00D);
        tick;
        do_write(32'hA000_0008, 32'hCAFE_F00D, 2'b10);
        chk_all_idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
